// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. Free-running x/y counters
//   advance on each pix_ce tick; sync, blanking, position and frame/line
//   strobes are decoded from the counters and passed through an OUT_DELAY
//   deep register line so all outputs stay mutually aligned and registered.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   pix_ce     pixel clock-enable; all state advances only when high
//   hsync      horizontal sync, asserted level H_POL
//   vsync      vertical sync, asserted level V_POL
//   de         display enable (pixel inside the active area)
//   x, y       raster position including blanking
//   sof        start of frame, high for the pixel at (0,0)
//   eol        end of line, high for the pixel at x = H_TOTAL-1
//   frame_cnt  completed-frame count, wraps at 2^FCW (not delayed)
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FP      = 56,
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BP      = 64,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FP      = 37,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BP      = 23,
    parameter bit          H_POL     = 1'b0,
    parameter bit          V_POL     = 1'b0,
    parameter int unsigned CW        = 11,
    parameter int unsigned FCW       = 8,
    parameter int unsigned OUT_DELAY = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_ce,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           sof,
    output logic           eol,
    output logic [FCW-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode thresholds are one bit wider than the counters so that a
    // total of exactly 2^CW still compares correctly.
    localparam int unsigned CX = CW + 1;
    localparam logic [CW:0] H_ACT_E = CX'(H_ACTIVE);
    localparam logic [CW:0] H_SS_E  = CX'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SE_E  = CX'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_E = CX'(V_ACTIVE);
    localparam logic [CW:0] V_SS_E  = CX'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SE_E  = CX'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          sof;
        logic          eol;
    } tap_t;

    localparam tap_t IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0,
                              x: '0, y: '0, sof: 1'b0, eol: 1'b0};

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW:0]   h_e;
    logic [CW:0]   v_e;
    logic          h_wrap;
    logic          v_wrap;
    tap_t          raw;
    tap_t          pipe [OUT_DELAY];

    assign h_e    = {1'b0, h_cnt};
    assign v_e    = {1'b0, v_cnt};
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_comb begin
        raw     = IDLE;
        raw.hs  = ((h_e >= H_SS_E) && (h_e < H_SE_E)) ? H_POL : ~H_POL;
        raw.vs  = ((v_e >= V_SS_E) && (v_e < V_SE_E)) ? V_POL : ~V_POL;
        raw.de  = (h_e < H_ACT_E) && (v_e < V_ACT_E);
        raw.x   = h_cnt;
        raw.y   = v_cnt;
        raw.sof = (h_cnt == '0) && (v_cnt == '0);
        raw.eol = h_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
            for (int unsigned i = 0; i < OUT_DELAY; i++) begin
                pipe[i] <= IDLE;
            end
        end else if (pix_ce) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt     <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            pipe[0] <= raw;
            for (int unsigned i = 1; i < OUT_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign hsync = pipe[OUT_DELAY-1].hs;
    assign vsync = pipe[OUT_DELAY-1].vs;
    assign de    = pipe[OUT_DELAY-1].de;
    assign x     = pipe[OUT_DELAY-1].x;
    assign y     = pipe[OUT_DELAY-1].y;
    assign sof   = pipe[OUT_DELAY-1].sof;
    assign eol   = pipe[OUT_DELAY-1].eol;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default-timing instance (A) and a small
// active-high-sync, 4-deep-delay, 2-bit frame counter instance (B) share
// clock, reset and pix_ce.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    logic        a_hsync, a_vsync, a_de, a_sof, a_eol;
    logic [10:0] a_x, a_y;
    logic [7:0]  a_fc;
    logic        b_hsync, b_vsync, b_de, b_sof, b_eol;
    logic [3:0]  b_x, b_y;
    logic [1:0]  b_fc;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst), .pix_ce(ce),
        .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
        .x(a_x), .y(a_y), .sof(a_sof), .eol(a_eol), .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4), .FCW(2), .OUT_DELAY(4)
    ) u_b (
        .clk(clk), .rst(rst), .pix_ce(ce),
        .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
        .x(b_x), .y(b_y), .sof(b_sof), .eol(b_eol), .frame_cnt(b_fc)
    );

    typedef struct {
        int hs, vs, de, sof, eol, x, y, fc;
    } exp_t;

    typedef struct {
        int   dut;
        int   k;
        exp_t e;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int dut, k, hs, vs, de, sof, eol, xx, yy, fc);
        vec_t v;
        v.dut = dut; v.k = k;
        v.e.hs = hs; v.e.vs = vs; v.e.de = de; v.e.sof = sof; v.e.eol = eol;
        v.e.x = xx; v.e.y = yy; v.e.fc = fc;
        return v;
    endfunction

    // Default timing: 1040 x 666, sync active-low, output lags counters by 1 tick.
    function automatic exp_t model_a(input int t);
        exp_t e;
        int n, h, v;
        e = '{hs: 1, vs: 1, de: 0, sof: 0, eol: 0, x: 0, y: 0, fc: (t / 692640) % 256};
        if (t >= 1) begin
            n = t - 1;
            h = n % 1040;
            v = (n / 1040) % 666;
            e.hs  = (h >= 856 && h < 976) ? 0 : 1;
            e.vs  = (v >= 637 && v < 643) ? 0 : 1;
            e.de  = (h < 800 && v < 600) ? 1 : 0;
            e.sof = (h == 0 && v == 0) ? 1 : 0;
            e.eol = (h == 1039) ? 1 : 0;
            e.x = h; e.y = v;
        end
        return e;
    endfunction

    // Small timing: 14 x 8, sync active-high, output lags counters by 4 ticks.
    function automatic exp_t model_b(input int t);
        exp_t e;
        int n, h, v;
        e = '{hs: 0, vs: 0, de: 0, sof: 0, eol: 0, x: 0, y: 0, fc: (t / 112) % 4};
        if (t >= 4) begin
            n = t - 4;
            h = n % 14;
            v = (n / 14) % 8;
            e.hs  = (h >= 10 && h < 13) ? 1 : 0;
            e.vs  = (v >= 5 && v < 7) ? 1 : 0;
            e.de  = (h < 8 && v < 4) ? 1 : 0;
            e.sof = (h == 0 && v == 0) ? 1 : 0;
            e.eol = (h == 13) ? 1 : 0;
            e.x = h; e.y = v;
        end
        return e;
    endfunction

    function automatic exp_t act_a();
        exp_t a;
        a = '{hs: int'(a_hsync), vs: int'(a_vsync), de: int'(a_de), sof: int'(a_sof),
              eol: int'(a_eol), x: int'(a_x), y: int'(a_y), fc: int'(a_fc)};
        return a;
    endfunction

    function automatic exp_t act_b();
        exp_t a;
        a = '{hs: int'(b_hsync), vs: int'(b_vsync), de: int'(b_de), sof: int'(b_sof),
              eol: int'(b_eol), x: int'(b_x), y: int'(b_y), fc: int'(b_fc)};
        return a;
    endfunction

    function automatic int ndiff(input exp_t a, input exp_t e);
        return int'(a.hs != e.hs) + int'(a.vs != e.vs) + int'(a.de != e.de) +
               int'(a.sof != e.sof) + int'(a.eol != e.eol) + int'(a.x != e.x) +
               int'(a.y != e.y) + int'(a.fc != e.fc);
    endfunction

    task automatic cmp_all(input string tag, input exp_t a, input exp_t e);
        check({tag, "_hsync"}, a.hs, e.hs);
        check({tag, "_vsync"}, a.vs, e.vs);
        check({tag, "_de"}, a.de, e.de);
        check({tag, "_sof"}, a.sof, e.sof);
        check({tag, "_eol"}, a.eol, e.eol);
        check({tag, "_x"}, a.x, e.x);
        check({tag, "_y"}, a.y, e.y);
        check({tag, "_frame_cnt"}, a.fc, e.fc);
    endtask

    initial begin
        int a_err, b_err, de_cnt, hs_low, eol_cnt, sof_cnt, e1, e2, prev_eol, t;
        exp_t idle_a, idle_b;

        // dut, k, hsync, vsync, de, sof, eol, x, y, frame_cnt
        tbl.push_back(mk(0,    1, 1, 1, 1, 1, 0,    0, 0, 0));
        tbl.push_back(mk(0,  800, 1, 1, 1, 0, 0,  799, 0, 0));
        tbl.push_back(mk(0,  801, 1, 1, 0, 0, 0,  800, 0, 0));
        tbl.push_back(mk(0,  856, 1, 1, 0, 0, 0,  855, 0, 0));
        tbl.push_back(mk(0,  857, 0, 1, 0, 0, 0,  856, 0, 0));
        tbl.push_back(mk(0,  976, 0, 1, 0, 0, 0,  975, 0, 0));
        tbl.push_back(mk(0,  977, 1, 1, 0, 0, 0,  976, 0, 0));
        tbl.push_back(mk(0, 1040, 1, 1, 0, 0, 1, 1039, 0, 0));
        tbl.push_back(mk(0, 1041, 1, 1, 1, 0, 0,    0, 1, 0));
        tbl.push_back(mk(0, 1441, 1, 1, 1, 0, 0,  400, 1, 0));
        tbl.push_back(mk(1,    1, 0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(1,    3, 0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(1,    4, 0, 0, 1, 1, 0,  0, 0, 0));
        tbl.push_back(mk(1,   11, 0, 0, 1, 0, 0,  7, 0, 0));
        tbl.push_back(mk(1,   12, 0, 0, 0, 0, 0,  8, 0, 0));
        tbl.push_back(mk(1,   14, 1, 0, 0, 0, 0, 10, 0, 0));
        tbl.push_back(mk(1,   16, 1, 0, 0, 0, 0, 12, 0, 0));
        tbl.push_back(mk(1,   17, 0, 0, 0, 0, 1, 13, 0, 0));
        tbl.push_back(mk(1,   18, 0, 0, 1, 0, 0,  0, 1, 0));
        tbl.push_back(mk(1,   74, 0, 1, 0, 0, 0,  0, 5, 0));
        tbl.push_back(mk(1,  101, 0, 1, 0, 0, 1, 13, 6, 0));
        tbl.push_back(mk(1,  102, 0, 0, 0, 0, 0,  0, 7, 0));
        tbl.push_back(mk(1,  111, 0, 0, 0, 0, 0,  9, 7, 0));
        tbl.push_back(mk(1,  112, 1, 0, 0, 0, 0, 10, 7, 1));
        tbl.push_back(mk(1,  116, 0, 0, 1, 1, 0,  0, 0, 1));
        tbl.push_back(mk(1,  224, 1, 0, 0, 0, 0, 10, 7, 2));
        tbl.push_back(mk(1,  336, 1, 0, 0, 0, 0, 10, 7, 3));
        tbl.push_back(mk(1,  448, 1, 0, 0, 0, 0, 10, 7, 0));
        tbl.push_back(mk(1,  559, 0, 0, 0, 0, 0,  9, 7, 0));
        tbl.push_back(mk(1,  560, 1, 0, 0, 0, 0, 10, 7, 1));

        idle_a = '{hs: 1, vs: 1, de: 0, sof: 0, eol: 0, x: 0, y: 0, fc: 0};
        idle_b = '{hs: 0, vs: 0, de: 0, sof: 0, eol: 0, x: 0, y: 0, fc: 0};

        // Reset state
        rst = 1'b1;
        ce  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_all("rst_a", act_a(), idle_a);
        cmp_all("rst_b", act_b(), idle_b);
        rst = 1'b0;

        // Continuous pix_ce: table vectors plus model over the whole run
        a_err = 0; b_err = 0; de_cnt = 0; hs_low = 0; eol_cnt = 0;
        for (int k = 1; k <= 1541; k++) begin
            @(posedge clk);
            #1;
            a_err += ndiff(act_a(), model_a(k));
            b_err += ndiff(act_b(), model_b(k));
            if (k <= 1040) begin
                de_cnt  += int'(a_de);
                hs_low  += int'(!a_hsync);
                eol_cnt += int'(a_eol);
            end
            foreach (tbl[i]) begin
                if (tbl[i].k == k) begin
                    cmp_all($sformatf("vec%0d", i), (tbl[i].dut == 0) ? act_a() : act_b(), tbl[i].e);
                end
            end
        end
        check("a_stream_diffs", a_err, 0);
        check("b_stream_diffs", b_err, 0);
        check("a_de_cycles_line0", de_cnt, 800);
        check("a_hsync_low_cycles_line0", hs_low, 120);
        check("a_eol_cycles_line0", eol_cnt, 1);
        // A now shows x=500,y=1; B has frame_cnt=1.
        check("pre_rst_a_x", int'(a_x), 500);
        check("pre_rst_b_fc", int'(b_fc), 1);

        // Asynchronous reset mid-line, between clock edges
        #2;
        rst = 1'b1;
        #1;
        cmp_all("async_rst_a", act_a(), idle_a);
        cmp_all("async_rst_b", act_b(), idle_b);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            cmp_all($sformatf("restart_a_t%0d", k), act_a(), model_a(k));
            cmp_all($sformatf("restart_b_t%0d", k), act_b(), model_b(k));
        end

        // pix_ce toggling 1,0,1,0: every second edge is a tick
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_err = 0; b_err = 0; sof_cnt = 0; eol_cnt = 0; e1 = -1; e2 = -1; prev_eol = 0;
        for (int c = 1; c <= 4200; c++) begin
            ce = (c % 2 == 1);
            @(posedge clk);
            #1;
            t = (c + 1) / 2;
            a_err += ndiff(act_a(), model_a(t));
            b_err += ndiff(act_b(), model_b(t));
            if (c <= 4) sof_cnt += int'(a_sof);
            if (c <= 2080) eol_cnt += int'(a_eol);
            if (a_eol && prev_eol == 0) begin
                if (e1 < 0) e1 = c;
                else if (e2 < 0) e2 = c;
            end
            prev_eol = int'(a_eol);
        end
        ce = 1'b1;
        check("toggle_a_diffs", a_err, 0);
        check("toggle_b_diffs", b_err, 0);
        check("toggle_sof_cycles", sof_cnt, 2);
        check("toggle_eol_cycles_line0", eol_cnt, 2);
        check("toggle_first_eol_cycle", e1, 2079);
        check("toggle_line_period", e2 - e1, 2080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
